toggle_cover_collector: RTL and testbench
=========================================

Name: toggle_cover_collector

Overview:
- Receiving end of the toggle-coverage reporting path. It consumes a per-point hit vector, where bit i means cover point COVER_INDEX+i toggled this cycle.
- Keeps a sticky covered bitmap and a count of points covered.
- Streams each first-time hit exactly once, as an absolute cover index, over a valid/ready port to the fuzzer-side coverage drain.
- Used in synthesizable and formal builds, where DPI reporting is unavailable.

Parameters:
- WIDTH, 34, number of cover points handled by this instance (1..64).
- COVER_INDEX, 0, absolute index of bit 0; out_index = COVER_INDEX + bit position.
- IDX_W, 64, width of out_index (matches longint cover index).
- CNT_W, 6, width of covered_count; must satisfy 2^CNT_W > WIDTH.

Ports:
- clock, input, 1, clock; all state updates on rising edge.
- reset, input, 1, synchronous, active-low reset.
- valid, input, WIDTH, per-point hit strobes for this cycle; any number of bits may be set.
- clear, input, 1, single-cycle pulse that forgets all coverage and pending reports.
- out_valid, output, 1, an absolute cover index is presented.
- out_ready, input, 1, consumer accepts out_index when out_valid&&out_ready.
- out_index, output, IDX_W, absolute index of a newly covered point.
- covered_count, output, CNT_W, number of distinct points covered since reset/clear.
- all_covered, output, 1, covered_count == WIDTH.
- busy, output, 1, pending bitmap non-zero or out_valid high.

Behaviour:
- Reset (reset==0 at an edge):
  - covered, pending, covered_count, out_valid, out_index, all_covered and busy go to 0.
  - valid is ignored in that cycle.
  - Reset mid-handshake drops the presented index with no acceptance.
- New-hit detection, each cycle with reset==1:
  - new = valid & ~covered.
  - covered |= new; pending |= new.
  - covered_count += popcount(new); cannot exceed WIDTH.
  - Repeated hits on a covered point have no effect.
- Output register, a one-entry skid:
  - Load condition: "slot free" = !out_valid || out_ready.
  - When the slot is free and pending != 0, load the lowest set bit p of pending.
  - On load: out_index = COVER_INDEX + p (zero-extended to IDX_W), out_valid = 1, and clear pending[p] in the same edge.
  - When the slot is free and pending == 0, out_valid = 0.
  - While out_valid && !out_ready, out_valid and out_index hold stable; this is a required handshake rule.
- Latency: a hit sampled at edge t sets pending at t. The earliest out_valid is the edge at t+1, i.e. 1 cycle from valid input to out_valid.
- Throughput: 1 index per cycle with out_ready held high.
- Ordering: among pending points, the lowest bit position is emitted first. Hits arriving later with a lower position may overtake earlier higher ones.
- Simultaneous new hit and load:
  - Pending used for selection is the registered pending. Same-cycle new hits are not emitted that cycle.
  - A new hit on a bit being loaded is impossible, since that bit is already covered.
- clear (reset==1, clear==1):
  - covered, pending and covered_count are zeroed; out_valid drops to 0.
  - Hits present on valid in the clear cycle are then applied as first hits: covered = pending = valid, count = popcount(valid).
  - A presented index with out_ready high in the clear cycle counts as accepted; otherwise it is discarded.
- Flow states (derived, not a separate FSM register):
  - IDLE: !busy.
  - DRAIN: pending != 0.
  - STALL: out_valid && !out_ready.
  - IDLE→DRAIN on any new hit. DRAIN→IDLE when the last index is accepted and pending == 0.
- all_covered and busy are registered-consistent: derived combinationally from registered state only, never from inputs.
- Total emitted indices between reset/clear events equals the final covered_count.

Test Plan:
- Reset: hold reset=0 with valid=all-ones for 3 cycles -> out_valid=0, covered_count=0 throughout; release with valid=0 -> no output.
- Burst with free drain: WIDTH=34, COVER_INDEX=100, single cycle valid=34'h3_0000_0005, out_ready=1 -> out_index sequence 100, 102, 132, 133 on consecutive cycles, starting 1 cycle after the hit; covered_count=4; busy=0 afterwards.
- Backpressure: valid bit 5 then bit 1 one cycle later, out_ready=0 for 4 cycles -> out_index=COVER_INDEX+5 held stable; after out_ready=1, emits +5 then +1.
- Duplicate suppression: hit bit 7 on 10 separate cycles -> exactly one emission of COVER_INDEX+7; covered_count=1.
- Full coverage: valid all-ones one cycle, out_ready=1 -> 34 emissions in ascending order; all_covered=1 from the hit edge onward; covered_count=34.
- Clear mid-stream: after the all-ones hit, wait 3 emissions, then pulse clear with valid=bit 9 and out_ready=0 -> the current index is discarded; covered_count=1; next emission is COVER_INDEX+9 only.

Source files
------------

// File: rtl/toggle_cover_collector.sv
// Toggle-coverage collector: sticky covered bitmap plus a lowest-first, once-only index stream.
// One cycle from hit to out_valid; out_valid/out_index hold steady while out_ready is low.
module toggle_cover_collector #(
   parameter int              WIDTH       = 34,
   parameter longint unsigned COVER_INDEX = 0,
   parameter int              IDX_W       = 64,
   parameter int              CNT_W       = 6
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [WIDTH-1:0]  valid,
   input  logic              clear,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [IDX_W-1:0]  out_index,
   output logic [CNT_W-1:0]  covered_count,
   output logic              all_covered,
   output logic              busy
);

   localparam int PW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   logic [WIDTH-1:0] covered;
   logic [WIDTH-1:0] pending;
   logic [WIDTH-1:0] new_hits;
   logic [WIDTH-1:0] load_mask;
   logic [PW-1:0]    sel_pos;
   logic             sel_found;
   logic             slot_free;
   logic             load;

   function automatic logic [CNT_W-1:0] popcount(input logic [WIDTH-1:0] v);
      logic [CNT_W-1:0] n;
      n = '0;
      for (int i = 0; i < WIDTH; i++) begin
         n = n + CNT_W'(v[i]);
      end
      return n;
   endfunction

   // Scan downward so the last match, the lowest set bit, wins.
   always_comb begin
      sel_found = 1'b0;
      sel_pos   = '0;
      for (int i = WIDTH - 1; i >= 0; i--) begin
         if (pending[i]) begin
            sel_found = 1'b1;
            sel_pos   = PW'(i);
         end
      end
   end

   assign new_hits  = valid & ~covered;
   assign slot_free = !out_valid || out_ready;
   assign load      = slot_free && sel_found;
   assign load_mask = load ? (WIDTH'(1) << sel_pos) : '0;

   always_ff @(posedge clock) begin
      if (!reset) begin
         covered       <= '0;
         pending       <= '0;
         covered_count <= '0;
         out_valid     <= 1'b0;
         out_index     <= '0;
      end else if (clear) begin
         // Hits seen in the clear cycle become the first hits of the new epoch.
         covered       <= valid;
         pending       <= valid;
         covered_count <= popcount(valid);
         out_valid     <= 1'b0;
      end else begin
         covered       <= covered | new_hits;
         pending       <= (pending & ~load_mask) | new_hits;
         covered_count <= covered_count + popcount(new_hits);
         if (slot_free) begin
            out_valid <= sel_found;
         end
         if (load) begin
            out_index <= IDX_W'(COVER_INDEX) + IDX_W'(sel_pos);
         end
      end
   end

   assign all_covered = (covered_count == CNT_W'(WIDTH));
   assign busy        = (|pending) || out_valid;

endmodule

// File: tb/tb_toggle_cover_collector.sv
// Bench for toggle_cover_collector: directed scenarios plus random traffic against a set-based model.
module tb_toggle_cover_collector;

   localparam int              WIDTH = 34;
   localparam longint unsigned CI    = 100;
   localparam int              IDX_W = 64;
   localparam int              CNT_W = 6;

   logic              clock = 1'b0;
   logic              reset;
   logic [WIDTH-1:0]  valid;
   logic              clear;
   logic              out_valid;
   logic              out_ready;
   logic [IDX_W-1:0]  out_index;
   logic [CNT_W-1:0]  covered_count;
   logic              all_covered;
   logic              busy;

   toggle_cover_collector #(.WIDTH(WIDTH), .COVER_INDEX(CI), .IDX_W(IDX_W), .CNT_W(CNT_W)) dut (
      .clock(clock), .reset(reset), .valid(valid), .clear(clear),
      .out_valid(out_valid), .out_ready(out_ready), .out_index(out_index),
      .covered_count(covered_count), .all_covered(all_covered), .busy(busy)
   );

   always #5 clock = ~clock;

   int errors = 0;
   int checks = 0;

   // Reference model: sets of covered/pending points and the presented slot.
   bit      m_cov  [WIDTH];
   bit      m_pend [WIDTH];
   bit      m_ov;
   longint  m_idx;
   int      m_cnt;

   longint  dut_log[$];
   int      epoch_emits;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic model_edge();
      int lo;
      if (!reset) begin
         for (int i = 0; i < WIDTH; i++) begin m_cov[i] = 0; m_pend[i] = 0; end
         m_ov = 0; m_idx = 0; m_cnt = 0;
      end else if (clear) begin
         for (int i = 0; i < WIDTH; i++) begin m_cov[i] = valid[i]; m_pend[i] = valid[i]; end
         m_cnt = 0;
         for (int i = 0; i < WIDTH; i++) m_cnt += int'(valid[i]);
         m_ov = 0;
      end else begin
         if (!m_ov || out_ready) begin
            lo = -1;
            for (int i = 0; i < WIDTH; i++) if (m_pend[i] && lo < 0) lo = i;
            if (lo >= 0) begin
               m_ov = 1; m_idx = longint'(CI) + lo; m_pend[lo] = 0;
            end else begin
               m_ov = 0;
            end
         end
         for (int i = 0; i < WIDTH; i++) begin
            if (valid[i] && !m_cov[i]) begin
               m_cov[i] = 1; m_pend[i] = 1; m_cnt++;
            end
         end
      end
   endtask

   task automatic compare();
      bit any_pend;
      any_pend = 0;
      for (int i = 0; i < WIDTH; i++) any_pend |= m_pend[i];
      chk("out_valid", 64'(out_valid), 64'(m_ov));
      if (m_ov) chk("out_index", out_index, m_idx);
      chk("covered_count", 64'(covered_count), 64'(m_cnt));
      chk("all_covered", 64'(all_covered), 64'(m_cnt == WIDTH));
      chk("busy", 64'(busy), 64'(any_pend || m_ov));
   endtask

   // Record DUT acceptances before the edge, advance the model at it, compare just after.
   task automatic step();
      if (reset && out_valid && out_ready) begin
         dut_log.push_back(longint'(out_index));
         epoch_emits++;
      end
      if (!reset || clear) epoch_emits = 0;
      @(posedge clock);
      model_edge();
      #1;
      compare();
   endtask

   task automatic run(input int n);
      for (int k = 0; k < n; k++) step();
   endtask

   task automatic check_log(input string tag, input longint exp[$]);
      chk({tag, "_len"}, 64'(dut_log.size()), 64'(exp.size()));
      for (int i = 0; i < exp.size(); i++)
         chk(tag, (i < dut_log.size()) ? dut_log[i] : 64'hFFFF_FFFF_FFFF_FFFF, exp[i]);
   endtask

   task automatic do_clear();
      clear = 1; valid = '0; out_ready = 1;
      step();
      clear = 0;
      run(2);
      dut_log.delete();
   endtask

   initial begin
      longint exp_q[$];
      int     guard;
      logic [WIDTH-1:0] rv;

      reset = 0; valid = '1; clear = 0; out_ready = 1;
      epoch_emits = 0;

      // Reset held with all hits asserted.
      for (int k = 0; k < 3; k++) begin
         step();
         chk("rst_out_valid", 64'(out_valid), 64'd0);
         chk("rst_count", 64'(covered_count), 64'd0);
      end
      chk("rst_out_index", out_index, 64'd0);
      reset = 1; valid = '0;
      run(3);
      chk("rst_no_output", 64'(dut_log.size()), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);

      // Burst with free drain.
      valid = 34'h3_0000_0005; out_ready = 1;
      step();
      valid = '0;
      chk("burst_idle_at_hit", 64'(out_valid), 64'd0);
      step();
      chk("burst_first_valid", 64'(out_valid), 64'd1);
      chk("burst_first_index", out_index, 64'd100);
      run(5);
      exp_q = '{100, 102, 132, 133};
      check_log("burst", exp_q);
      chk("burst_count", 64'(covered_count), 64'd4);
      chk("burst_busy", 64'(busy), 64'd0);

      // Backpressure.
      do_clear();
      out_ready = 0; valid = WIDTH'(1) << 5;
      step();
      valid = WIDTH'(1) << 1;
      step();
      chk("bp_index0", out_index, CI + 5);
      valid = '0;
      for (int k = 0; k < 2; k++) begin
         step();
         chk("bp_hold_valid", 64'(out_valid), 64'd1);
         chk("bp_hold_index", out_index, CI + 5);
      end
      out_ready = 1;
      run(4);
      exp_q = '{CI + 5, CI + 1};
      check_log("bp", exp_q);

      // Duplicate suppression.
      do_clear();
      for (int k = 0; k < 10; k++) begin
         valid = WIDTH'(1) << 7; step();
         valid = '0; step();
      end
      exp_q = '{CI + 7};
      check_log("dup", exp_q);
      chk("dup_count", 64'(covered_count), 64'd1);

      // Full coverage.
      do_clear();
      valid = '1;
      step();
      valid = '0;
      chk("full_all_covered_at_hit", 64'(all_covered), 64'd1);
      run(37);
      exp_q.delete();
      for (int i = 0; i < WIDTH; i++) exp_q.push_back(CI + i);
      check_log("full", exp_q);
      chk("full_count", 64'(covered_count), 64'd34);

      // Clear mid-stream.
      do_clear();
      valid = '1;
      step();
      valid = '0;
      guard = 0;
      while (dut_log.size() < 3 && guard < 10) begin step(); guard++; end
      chk("mid_wait", 64'(dut_log.size()), 64'd3);
      dut_log.delete();
      clear = 1; valid = WIDTH'(1) << 9; out_ready = 0;
      step();
      clear = 0; valid = '0;
      chk("mid_count", 64'(covered_count), 64'd1);
      chk("mid_dropped", 64'(out_valid), 64'd0);
      out_ready = 1;
      run(4);
      exp_q = '{CI + 9};
      check_log("mid", exp_q);

      // Random traffic with occasional clear and reset.
      for (int k = 0; k < 3000; k++) begin
         rv = WIDTH'({$urandom, $urandom}) & WIDTH'({$urandom, $urandom}) & WIDTH'({$urandom, $urandom});
         valid     = ($urandom_range(0, 3) == 0) ? '0 : rv;
         out_ready = ($urandom_range(0, 2) != 0);
         clear     = ($urandom_range(0, 60) == 0);
         reset     = ($urandom_range(0, 250) != 0);
         step();
      end
      reset = 1; clear = 0; valid = '0; out_ready = 1;
      run(WIDTH + 4);
      chk("epoch_emits_eq_count", 64'(epoch_emits), 64'(covered_count));
      chk("drained_busy", 64'(busy), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
